maxpool_2x2_stream: RTL
=======================

Name: maxpool_2x2_stream

Overview:
- Downstream of the ReLU stage; consumes its 8-bit unsigned activations in raster order, one pixel per valid cycle.
- Performs VGG-16 2x2 max-pooling with stride 2, producing an (IMG_W/2) x (IMG_H/2) map in raster order.
- Uses a half-row line buffer: each even row's horizontal pair maxima wait there for the matching odd-row pair.
- Valid-only streaming, no backpressure; tolerates arbitrary gaps in in_valid.

Parameters:
- DATA_W, 8, activation width; matches the ReLU output width.
- IMG_W, 224, input row length in pixels; must be even and >= 2.
- IMG_H, 224, input rows per frame; must be even and >= 2.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous soft clear; resynchronises to start of frame.
- in_valid  input  1  pix_in is valid this cycle.
- pix_in  input  DATA_W  unsigned activation from the ReLU stage.
- out_valid  output  1  pool_out is valid this cycle (one-cycle pulse per pooled pixel).
- pool_out  output  DATA_W  pooled maximum.
- frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

Behaviour:
- Reset: out_valid=0, pool_out=0, frame_done=0, col=0, row=0, pair register=0. Line buffer contents are don't-care; they are never read before being written.
- clear: same effect as reset on all registers except the line buffer, applied on the clock edge. clear has priority over in_valid in the same cycle.
- Counters:
  - col counts 0..IMG_W-1 and advances only on in_valid.
  - row counts 0..IMG_H-1 and advances when col wraps.
  - After the last pixel of a frame, both counters return to 0.
  - With in_valid=0, all state holds.
- Even column (col[0]=0): register the pixel as the pair register `hold`.
- Odd column:
  - Compute h = max(hold, pix_in), unsigned compare.
  - Even row: write h to line buffer entry col>>1.
  - Odd row: compute max(h, linebuf[col>>1]).
  - Read and write of the same entry never occur in the same row, so there is no read-during-write hazard.
- Output timing: on an odd row at an odd column, pool_out and out_valid are registered one cycle after the accepting edge. Latency is 1 clk from the 4th pixel of each window.
- out_valid is 0 in every other cycle; pool_out holds its last value when out_valid=0.
- frame_done=1 in the same cycle as the out_valid for window (IMG_W/2-1, IMG_H/2-1).
- Back-to-back frames: a new frame's pixel 0 may arrive the cycle after the previous frame's last pixel.
- Equal values: max returns that value; no tie-break concerns.
- Width: pure compare/select, no arithmetic growth; DATA_W in equals DATA_W out.
- Async reset mid-frame: all outputs drop to their reset values immediately. The partial frame is discarded and the next accepted pixel is treated as (0,0).
- Line buffer: IMG_W/2 entries x DATA_W, index width = clog2(IMG_W/2).
- Elaboration check: an odd IMG_W or IMG_H is a fatal error.

Decomposition:
- Shared package (pool_pkg):
  - DATA_W default.
  - VGG layer dimension constants (224, 112, 56, 28, 14).
  - An index-width function clog2.
- One sub-module, pool_line_buf: a single-port synchronous RAM of IMG_W/2 x DATA_W with registered read.
  - Read address is issued on the even-column cycle of an odd row so that data is ready at the odd column.
  - No reset on the array.
- Top level holds the counters, pair register, compare muxes and output registers.

Test Plan:
- 4x4 frame (IMG_W=IMG_H=4), pixels 1..16, in_valid continuous -> out_valid pulses 4 times with pool_out 6,8,14,16; frame_done coincides with the 16; each pulse is 1 clk after pixels 6,8,14,16 are accepted.
- Same frame with in_valid toggling 1/0 every cycle -> identical output values and order; each out_valid still 1 clk after its 4th pixel; no spurious pulses.
- Window {200,0,0,255}, then window {7,7,7,7} -> pool_out 255 then 7, confirming unsigned compare (no sign interpretation of 255 or 200).
- Two back-to-back 4x4 frames, second all zeros -> outputs 6,8,14,16 then 0,0,0,0; frame_done pulses twice.
- Assert rst asynchronously after 10 pixels -> out_valid, frame_done and pool_out go to 0 before the next edge; a fresh 16-pixel frame then yields correct results.
- Assert clear together with in_valid at pixel 5 -> pixel 5 is dropped, counters return to 0, and the next 16 pixels pool correctly.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pooling stream.
// Provides the default activation width, the VGG-16 feature-map edge
// lengths seen along the pooling chain, and an index-width helper.
package pool_pkg;

  localparam int DEF_DATA_W = 8;

  // VGG-16 spatial sizes at successive pooling stages.
  localparam int VGG_DIM_224 = 224;
  localparam int VGG_DIM_112 = 112;
  localparam int VGG_DIM_56  = 56;
  localparam int VGG_DIM_28  = 28;
  localparam int VGG_DIM_14  = 14;

  // Ceiling log2, clamped to 1 so that single-entry structures still get a
  // legal one-bit index.
  function automatic int pool_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer: single-port synchronous RAM with registered read.
// Ports:
//   clk   - clock
//   en    - access enable; with en=0 rdata holds its last value
//   we    - 1: write wdata to addr, 0: read addr into rdata
//   addr  - entry index (pair column)
//   wdata - horizontal pair maximum from an even row
//   rdata - registered read data for the odd-row pair
// The array has no reset; every entry is written before it is read.
module pool_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 112,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 max-pooling over a raster-order activation stream.
// Horizontal pair maxima of each even row are parked in a half-row line
// buffer and combined with the matching odd-row pair to form the window max.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset
//   clear      - synchronous soft clear, restarts at pixel (0,0)
//   in_valid   - pix_in is valid this cycle
//   pix_in     - unsigned activation
//   out_valid  - one-cycle pulse per pooled pixel
//   pool_out   - pooled maximum, holds when out_valid=0
//   frame_done - pulse with the last pooled pixel of a frame
module maxpool_2x2_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = VGG_DIM_224,
  parameter int IMG_H  = VGG_DIM_224
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pix_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] pool_out,
  output logic              frame_done
);

  localparam int COL_W  = pool_clog2(IMG_W);
  localparam int ROW_W  = pool_clog2(IMG_H);
  localparam int DEPTH  = IMG_W / 2;
  localparam int ADDR_W = pool_clog2(DEPTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
    $fatal(1, "maxpool_2x2_stream: IMG_W and IMG_H must be even and >= 2");
  end

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] pool_p1;
  logic              vld_p1;
  logic              done_p1;

  logic              acc_p0;
  logic              buf_en;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] buf_rdata;
  logic [ADDR_W-1:0] buf_addr;

  // Stage p0: accept pixel, form pair max, access line buffer
  assign acc_p0   = in_valid & ~clear;
  assign pair_max = umax(hold, pix_in);
  assign buf_addr = ADDR_W'(col >> 1);
  // Even row writes at the odd column; odd row pre-reads at the even column
  // so the registered data is ready when the odd column arrives.
  assign buf_en   = acc_p0 & (row[0] ^ col[0]);

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk   (clk),
    .en    (buf_en),
    .we    (~row[0]),
    .addr  (buf_addr),
    .wdata (pair_max),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      hold    <= '0;
      pool_p1 <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else if (clear) begin
      col     <= '0;
      row     <= '0;
      hold    <= '0;
      pool_p1 <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (in_valid) begin
        if (!col[0]) begin
          hold <= pix_in;
        end else if (row[0]) begin
          pool_p1 <= umax(pair_max, buf_rdata);
          vld_p1  <= 1'b1;
          done_p1 <= (col == COL_LAST) && (row == ROW_LAST);
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Stage p1: registered outputs
  assign out_valid  = vld_p1;
  assign pool_out   = pool_p1;
  assign frame_done = done_p1;

endmodule
